// File: rtl/pwm_pkg.sv
// Shared definitions for the pwm block and its duty-cycle fade generator.
package pwm_pkg;

    localparam int unsigned PWM_CTR_LEN = 8;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        UP      = 3'd1,
        HOLD_HI = 3'd2,
        DOWN    = 3'd3,
        HOLD_LO = 3'd4
    } fade_state_e;

endpackage

// File: rtl/pwm_fade_gen_tick_div.sv
// Step-rate prescaler: count 0..div_i, single-cycle tick on the terminal count.
module tick_div #(
    parameter int unsigned DIV_LEN = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clr_i,
    input  logic [DIV_LEN-1:0] div_i,
    output logic               tick_o
);

    logic [DIV_LEN-1:0] cnt_q, cnt_d;

    assign tick_o = (cnt_q == div_i);

    always_comb begin
        cnt_d = cnt_q + DIV_LEN'(1);
        if (clr_i || tick_o) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/pwm_fade_gen.sv
// Breathing triangle generator feeding the pwm compare input:
// ramp up to max, dwell, ramp down to min, dwell, repeat while enabled.
module pwm_fade_gen
    import pwm_pkg::*;
#(
    parameter int unsigned CTR_LEN  = PWM_CTR_LEN,
    parameter int unsigned DIV_LEN  = 16,
    parameter int unsigned HOLD_LEN = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                enable,
    input  logic [CTR_LEN-1:0]  level_min,
    input  logic [CTR_LEN-1:0]  level_max,
    input  logic [CTR_LEN-1:0]  step,
    input  logic [DIV_LEN-1:0]  div,
    input  logic [HOLD_LEN-1:0] hold,
    output logic [CTR_LEN-1:0]  compare,
    output logic                busy,
    output logic                cycle_done
);

    fade_state_e         state_q, state_d;
    logic [CTR_LEN-1:0]  compare_q, compare_d;
    logic [HOLD_LEN-1:0] hold_cnt_q, hold_cnt_d;
    logic                busy_q, done_q, done_d;

    logic [CTR_LEN-1:0]  min_l_q, max_l_q, step_l_q;
    logic [HOLD_LEN-1:0] hold_l_q;
    logic [DIV_LEN-1:0]  div_l_q;

    logic                latch, clr, tick;
    logic [CTR_LEN:0]    sum, floor_lvl;

    tick_div #(
        .DIV_LEN(DIV_LEN)
    ) u_tick_div (
        .clk    (clk),
        .rst    (rst),
        .clr_i  (clr),
        .div_i  (div_l_q),
        .tick_o (tick)
    );

    // Widened by one bit so saturation and underflow are decided without wrap.
    assign sum       = {1'b0, compare_q} + {1'b0, step_l_q};
    assign floor_lvl = {1'b0, min_l_q} + {1'b0, step_l_q};

    always_comb begin
        state_d    = state_q;
        compare_d  = compare_q;
        hold_cnt_d = hold_cnt_q;
        done_d     = 1'b0;
        latch      = 1'b0;
        clr        = 1'b0;
        case (state_q)
            IDLE: begin
                if (enable) begin
                    latch     = 1'b1;
                    clr       = 1'b1;
                    compare_d = level_min;
                    state_d   = UP;
                end
            end
            UP: begin
                if (tick) begin
                    if (sum >= {1'b0, max_l_q}) begin
                        compare_d  = max_l_q;
                        hold_cnt_d = '0;
                        state_d    = HOLD_HI;
                    end else begin
                        compare_d = sum[CTR_LEN-1:0];
                    end
                end
            end
            HOLD_HI: begin
                if (tick) begin
                    if (hold_cnt_q == hold_l_q) begin
                        state_d = DOWN;
                    end else begin
                        hold_cnt_d = hold_cnt_q + HOLD_LEN'(1);
                    end
                end
            end
            DOWN: begin
                if (tick) begin
                    if ({1'b0, compare_q} < floor_lvl) begin
                        compare_d  = min_l_q;
                        hold_cnt_d = '0;
                        state_d    = HOLD_LO;
                    end else begin
                        compare_d = compare_q - step_l_q;
                    end
                end
            end
            HOLD_LO: begin
                if (tick) begin
                    if (hold_cnt_q == hold_l_q) begin
                        done_d = 1'b1;
                        if (enable) begin
                            latch     = 1'b1;
                            compare_d = level_min;
                            state_d   = UP;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        hold_cnt_d = hold_cnt_q + HOLD_LEN'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            compare_q  <= '0;
            hold_cnt_q <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            compare_q  <= compare_d;
            hold_cnt_q <= hold_cnt_d;
            busy_q     <= (state_d != IDLE);
            done_q     <= done_d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            min_l_q  <= '0;
            max_l_q  <= '0;
            step_l_q <= CTR_LEN'(1);
            hold_l_q <= '0;
            div_l_q  <= '0;
        end else if (latch) begin
            min_l_q  <= level_min;
            max_l_q  <= (level_min >= level_max) ? level_min : level_max;
            step_l_q <= (step == '0) ? CTR_LEN'(1) : step;
            hold_l_q <= hold;
            div_l_q  <= div;
        end
    end

    assign compare    = compare_q;
    assign busy       = busy_q;
    assign cycle_done = done_q;

endmodule

// File: tb/tb_pwm_fade_gen.sv
// Directed bench for pwm_fade_gen: per-clock compare profiles checked against hand-derived run tables.
module tb_pwm_fade_gen;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic [7:0]  level_min, level_max, step;
    logic [15:0] div;
    logic [7:0]  hold;
    logic [7:0]  compare;
    logic        busy, cycle_done;

    int unsigned n_vec = 0;
    int unsigned n_bad = 0;

    int unsigned run_val [0:15];
    int unsigned run_cnt [0:15];
    int unsigned n_runs;

    pwm_fade_gen #(
        .CTR_LEN (8),
        .DIV_LEN (16),
        .HOLD_LEN(8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .level_min  (level_min),
        .level_max  (level_max),
        .step       (step),
        .div        (div),
        .hold       (hold),
        .compare    (compare),
        .busy       (busy),
        .cycle_done (cycle_done)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic clear_runs();
        n_runs = 0;
    endtask

    task automatic add_run(input int unsigned v, input int unsigned c);
        run_val[n_runs] = v;
        run_cnt[n_runs] = c;
        n_runs++;
    endtask

    task automatic set_cfg(input int unsigned mn, input int unsigned mx, input int unsigned st,
                           input int unsigned dv, input int unsigned hd);
        level_min = 8'(mn);
        level_max = 8'(mx);
        step      = 8'(st);
        div       = 16'(dv);
        hold      = 8'(hd);
    endtask

    // Sample after each active edge; optionally drop enable / scramble config after the first one.
    task automatic play_runs(input bit drop_en, input bit scramble);
        bit first = 1'b1;
        for (int unsigned r = 0; r < n_runs; r++) begin
            for (int unsigned c = 0; c < run_cnt[r]; c++) begin
                @(negedge clk);
                check_eq("compare", 32'(compare), 32'(run_val[r]));
                check_eq("busy", 32'(busy), 32'd1);
                check_eq("cycle_done", 32'(cycle_done), 32'd0);
                if (first) begin
                    first = 1'b0;
                    if (drop_en) enable = 1'b0;
                    if (scramble) set_cfg(50, 200, 7, 5, 7);
                end
            end
        end
    endtask

    task automatic check_end(input int unsigned exp_cmp);
        @(negedge clk);
        check_eq("end_compare", 32'(compare), 32'(exp_cmp));
        check_eq("end_busy", 32'(busy), 32'd0);
        check_eq("end_done", 32'(cycle_done), 32'd1);
        @(negedge clk);
        check_eq("idle_compare", 32'(compare), 32'(exp_cmp));
        check_eq("idle_busy", 32'(busy), 32'd0);
        check_eq("idle_done", 32'(cycle_done), 32'd0);
    endtask

    initial begin
        rst = 1'b0;
        enable = 1'b0;
        set_cfg(0, 0, 0, 0, 0);

        // reset held with random inputs
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            enable = 1'($urandom);
            set_cfg($urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255),
                    $urandom_range(0, 3), $urandom_range(0, 3));
            #1;
            check_eq("rst_compare", 32'(compare), 32'd0);
            check_eq("rst_busy", 32'(busy), 32'd0);
            check_eq("rst_done", 32'(cycle_done), 32'd0);
        end
        @(negedge clk);
        enable = 1'b0;
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_eq("post_rst_compare", 32'(compare), 32'd0);
            check_eq("post_rst_busy", 32'(busy), 32'd0);
        end

        // basic cycle, enable pulsed for one clock
        set_cfg(0, 128, 32, 0, 0);
        enable = 1'b1;
        clear_runs();
        add_run(0, 1); add_run(32, 1); add_run(64, 1); add_run(96, 1);
        add_run(128, 2); add_run(96, 1); add_run(64, 1); add_run(32, 1); add_run(0, 2);
        play_runs(1'b1, 1'b0);
        check_end(0);

        // saturation with enable held: second cycle follows immediately
        set_cfg(10, 250, 100, 0, 0);
        enable = 1'b1;
        clear_runs();
        add_run(10, 1); add_run(110, 1); add_run(210, 1); add_run(250, 2);
        add_run(150, 1); add_run(50, 1); add_run(10, 1);
        play_runs(1'b0, 1'b0);
        @(negedge clk);
        check_eq("sat_wrap_compare", 32'(compare), 32'd10);
        check_eq("sat_wrap_busy", 32'(busy), 32'd1);
        check_eq("sat_wrap_done", 32'(cycle_done), 32'd1);
        clear_runs();
        add_run(110, 1);
        play_runs(1'b0, 1'b0);
        enable = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (!busy) break;
        end
        check_eq("sat_idle_busy", 32'(busy), 32'd0);
        check_eq("sat_idle_done", 32'(cycle_done), 32'd1);
        check_eq("sat_idle_compare", 32'(compare), 32'd10);
        @(negedge clk);

        // prescaler div=3 and hold=2: 4 clk per step, 12 clk dwell
        set_cfg(0, 255, 64, 3, 2);
        enable = 1'b1;
        clear_runs();
        add_run(0, 4); add_run(64, 4); add_run(128, 4); add_run(192, 4);
        add_run(255, 16); add_run(191, 4); add_run(127, 4); add_run(63, 4); add_run(0, 12);
        play_runs(1'b1, 1'b0);
        check_end(0);

        // disable during UP and change config mid-cycle
        set_cfg(0, 100, 25, 0, 0);
        enable = 1'b1;
        clear_runs();
        add_run(0, 1); add_run(25, 1); add_run(50, 1); add_run(75, 1);
        add_run(100, 2); add_run(75, 1); add_run(50, 1); add_run(25, 1); add_run(0, 2);
        play_runs(1'b1, 1'b1);
        check_end(0);

        // step=0 ramps by 1
        set_cfg(0, 3, 0, 0, 0);
        enable = 1'b1;
        clear_runs();
        add_run(0, 1); add_run(1, 1); add_run(2, 1); add_run(3, 2);
        add_run(2, 1); add_run(1, 1); add_run(0, 2);
        play_runs(1'b1, 1'b0);
        check_end(0);

        // min above max: compare pinned at min, states still sequenced
        set_cfg(200, 100, 10, 0, 0);
        enable = 1'b1;
        clear_runs();
        add_run(200, 4);
        play_runs(1'b1, 1'b0);
        check_end(200);

        // async reset in the middle of DOWN
        set_cfg(0, 128, 32, 0, 0);
        enable = 1'b1;
        clear_runs();
        add_run(0, 1); add_run(32, 1); add_run(64, 1); add_run(96, 1);
        add_run(128, 2); add_run(96, 1);
        play_runs(1'b1, 1'b0);
        rst = 1'b0;
        #1;
        check_eq("arst_compare", 32'(compare), 32'd0);
        check_eq("arst_busy", 32'(busy), 32'd0);
        check_eq("arst_done", 32'(cycle_done), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_eq("arst_idle_compare", 32'(compare), 32'd0);
            check_eq("arst_idle_busy", 32'(busy), 32'd0);
            check_eq("arst_idle_done", 32'(cycle_done), 32'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/pwm_fade_gen.md
Name: pwm_fade_gen

Overview:
Duty-cycle ramp generator that sits directly upstream of the pwm block and drives its compare input. It produces a "breathing" triangle profile: it ramps compare from a low level to a high level in programmable steps, holds, ramps back down, and holds again. Step rate is set by an internal prescaler. The block repeats while enabled and finishes the current cycle gracefully when disabled.

Parameters:
CTR_LEN, 8, width of compare; must match the pwm instance CTR_LEN.
DIV_LEN, 16, width of the prescaler divide value.
HOLD_LEN, 8, width of the hold-time count.

Ports:
clk  input  1  system clock
rst  input  1  reset, asynchronous, active-low
enable  input  1  run request; level-sensitive
level_min  input  CTR_LEN  low end of ramp
level_max  input  CTR_LEN  high end of ramp
step  input  CTR_LEN  compare increment/decrement per tick; 0 is treated as 1
div  input  DIV_LEN  tick every div+1 clk cycles
hold  input  HOLD_LEN  dwell at each extreme = hold+1 ticks
compare  output  CTR_LEN  registered duty value to pwm
busy  output  1  high whenever state != IDLE
cycle_done  output  1  one-clk pulse at the end of each full triangle cycle

Behaviour:
- Reset (rst=0, async): compare=0, busy=0, cycle_done=0, state=IDLE, prescaler=0, hold_cnt=0. Reset mid-operation aborts immediately; no cycle_done pulse.
- Config latch: level_min, level_max, step and hold are latched into min_l, max_l, step_l and hold_l on every entry to UP (from IDLE or from HOLD_LO). Input changes mid-cycle are ignored. div is latched at the same time.
- If level_min >= level_max, then max_l=min_l. If step=0, then step_l=1.
- Prescaler: counts 0..div_l. A tick is generated in the cycle where count==div_l, and the count then wraps to 0. With div=0 there is a tick every clk. The prescaler is cleared on entry to UP from IDLE.
- States: IDLE, UP, HOLD_HI, DOWN, HOLD_LO.
- IDLE: compare holds its last value. If enable=1, then next clk: compare<=level_min, state->UP, latch config.
- UP, on tick: compute compare+step_l in CTR_LEN+1 bits.
  - If the sum >= max_l: compare<=max_l, hold_cnt<=0, state->HOLD_HI.
  - Otherwise: compare<=sum.
  - This handles saturation; no wrap-around is permitted.
- HOLD_HI, on tick: if hold_cnt==hold_l, then state->DOWN; otherwise hold_cnt++.
- DOWN, on tick: if compare < min_l+step_l (CTR_LEN+1 bits), then compare<=min_l, hold_cnt<=0, state->HOLD_LO. Otherwise compare<=compare-step_l. No underflow is permitted.
- HOLD_LO, on tick with hold_cnt==hold_l: cycle_done=1 for one clk. Then state->UP (re-latching config) if enable=1, otherwise state->IDLE.
- Disable mid-run: enable is sampled only at the end of HOLD_LO (and in IDLE). The current cycle always completes, and compare ends at min_l.
- Outputs are registered. compare changes only on tick edges and at start.
- Latency: start->UP is 1 clk. After that, one compare update per tick.

Decomposition:
- Shared package pwm_pkg: the fade state enum (IDLE, UP, HOLD_HI, DOWN, HOLD_LO) and the default CTR_LEN constant shared with pwm.
- One sub-module, tick_div: a DIV_LEN prescaler with sync clear. It outputs a single-cycle tick.

Test Plan:
- Reset: hold rst=0 with random inputs. Expect compare=0, busy=0, cycle_done=0. Release rst: expect no change while enable=0.
- Basic cycle: min=0, max=128, step=32, div=0, hold=0; pulse enable for 1 clk. Expect compare sequence 0,32,64,96,128 (held 1 tick), then 96,64,32,0 (held 1 tick). Expect one cycle_done pulse, then busy=0.
- Saturation: min=10, max=250, step=100, enable held. Expect 10,110,210,250,150,50,10 with no wrap. Expect a second cycle to start immediately after cycle_done.
- Prescaler/hold: div=3, hold=2, step=64, min=0, max=255. Expect compare to change only every 4 clk and to dwell 12 clk at 255 and at 0.
- Disable mid-ramp: deassert enable during UP. Expect the cycle to complete to 0, cycle_done to pulse, IDLE. Config changes mid-cycle must not affect the ramp.
- Corners: step=0 gives ramp by 1. min=200, max=100 gives compare constant at 200, with busy and cycle_done still sequenced. Async rst mid-DOWN clears all outputs immediately.
